// File: rtl/decoder_nto2n_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : decoder_nto2n_pipe
//  Purpose  : Registered N_IN-to-2**N_IN one-hot decoder with valid/ready
//             handshake and a sweep mode that walks every output line once.
//             Macro DECODER_ACTIVE_LOW_EN selects active-low out_y.
//  Revision : 1.0 - initial release
// ============================================================================
module decoder_nto2n_pipe #(
    parameter int N_IN = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 mode,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N_IN-1:0]      in_sel,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [(1<<N_IN)-1:0] out_y,
    output logic                 sweep_done
);

    localparam int W = 1 << N_IN;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SWEEP = 1'b1;

    localparam logic [N_IN:0]   CNT_ONE  = (N_IN+1)'(1);
    localparam logic [N_IN:0]   CNT_FULL = {1'b1, {N_IN{1'b0}}};
    localparam logic [N_IN-1:0] IDX_ONE  = N_IN'(1);

`ifdef DECODER_ACTIVE_LOW_EN
    localparam logic [W-1:0] Y_POL = {W{1'b1}};
`else
    localparam logic [W-1:0] Y_POL = {W{1'b0}};
`endif

    logic [0:0]      state_q,      state_d;
    logic            out_valid_q,  out_valid_d;
    logic [N_IN-1:0] idx_q,        idx_d;
    logic [N_IN:0]   cnt_q,        cnt_d;
    logic            sweep_done_q, sweep_done_d;
    logic [W-1:0]    out_y_q,      out_y_d;

    logic w_accept;
    logic w_consume;
    logic [W-1:0] w_onehot;

    // The cycle carrying sweep_done keeps the input closed, even though the FSM is already idle.
    assign in_ready  = !rst && en && (state_q == ST_IDLE) && !sweep_done_q
                       && (!out_valid_q || out_ready);
    assign w_accept  = in_valid && in_ready;
    assign w_consume = out_valid_q && out_ready;

    always_comb begin
        state_d      = state_q;
        out_valid_d  = out_valid_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        sweep_done_d = 1'b0;

        if (!en) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            cnt_d       = '0;
        end else if (state_q == ST_IDLE) begin
            if (w_accept) begin
                out_valid_d = 1'b1;
                idx_d       = in_sel;
                if (mode) begin
                    state_d = ST_SWEEP;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end else if (w_consume) begin
                out_valid_d = 1'b0;
            end
        end else begin
            if (w_consume) begin
                if (cnt_q == CNT_FULL) begin
                    out_valid_d  = 1'b0;
                    state_d      = ST_IDLE;
                    cnt_d        = '0;
                    sweep_done_d = 1'b1;
                end else begin
                    idx_d = idx_q + IDX_ONE;
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
        end
    end

    // Output is decoded from next-state values so the one-hot lands in a register.
    always_comb begin
        w_onehot = {{(W-1){1'b0}}, 1'b1} << idx_d;
        out_y_d  = (out_valid_d ? w_onehot : {W{1'b0}}) ^ Y_POL;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            out_valid_q  <= 1'b0;
            idx_q        <= '0;
            cnt_q        <= '0;
            sweep_done_q <= 1'b0;
            out_y_q      <= Y_POL;
        end else begin
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            sweep_done_q <= sweep_done_d;
            out_y_q      <= out_y_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_y      = out_y_q;
    assign sweep_done = sweep_done_q;

endmodule
`default_nettype wire

// File: tb/tb_decoder_nto2n_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decoder_nto2n_pipe
//  Purpose  : Directed and randomized checks of decoder_nto2n_pipe (N_IN=3).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_decoder_nto2n_pipe;

    localparam int N_IN = 3;
    localparam int W    = 1 << N_IN;

`ifdef DECODER_ACTIVE_LOW_EN
    localparam logic [W-1:0] POL = {W{1'b1}};
`else
    localparam logic [W-1:0] POL = {W{1'b0}};
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic            mode;
    logic            in_valid;
    logic            in_ready;
    logic [N_IN-1:0] in_sel;
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    out_y;
    logic            sweep_done;

    int checks = 0;
    int errors = 0;

    decoder_nto2n_pipe #(.N_IN(N_IN)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .mode       (mode),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sel     (in_sel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_y      (out_y),
        .sweep_done (sweep_done)
    );

    always #5 clk = ~clk;

    // Physical level of out_y for a logical (active-high) pattern.
    function automatic logic [W-1:0] act(input logic [W-1:0] y);
        return y ^ POL;
    endfunction

    function automatic logic [W-1:0] line(input int i);
        logic [W-1:0] v;
        v = '0;
        v[i % W] = 1'b1;
        return v;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b1; mode = 1'b0; in_valid = 1'b0; in_sel = '0; out_ready = 1'b0;
        tick; tick;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
        checks++;
        if (out_y !== act('0)) begin errors++; $display("FAIL reset_y got %h want %h", out_y, act('0)); end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        checks++;
        if (sweep_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", sweep_done); end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
        tick;
    endtask

    task automatic test_direct_stream;
        out_ready = 1'b1; mode = 1'b0;
        for (int i = 0; i < W; i++) begin
            in_valid = 1'b1; in_sel = N_IN'(i);
            #1;
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d] got %b want 1", i, in_ready); end
            tick;
            checks++;
            if (out_valid !== 1'b1 || out_y !== act(line(i)))
                begin errors++; $display("FAIL stream_beat[%0d] got v=%b y=%h want v=1 y=%h", i, out_valid, out_y, act(line(i))); end
        end
        in_valid = 1'b0;
        tick;
        checks++;
        if (out_valid !== 1'b0 || out_y !== act('0))
            begin errors++; $display("FAIL stream_drain got v=%b y=%h want v=0 y=%h", out_valid, out_y, act('0)); end
    endtask

    task automatic test_backpressure;
        in_valid = 1'b1; in_sel = 3'd3; mode = 1'b0; out_ready = 1'b0;
        tick;
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_y !== act(8'h08) || in_ready !== 1'b0)
                begin errors++; $display("FAIL bp_hold[%0d] got v=%b y=%h rdy=%b want v=1 y=%h rdy=0", k, out_valid, out_y, in_ready, act(8'h08)); end
            tick;
        end
        out_ready = 1'b1;
        tick;
        checks++;
        if (out_valid !== 1'b0 || out_y !== act('0))
            begin errors++; $display("FAIL bp_release got v=%b y=%h want v=0 y=%h", out_valid, out_y, act('0)); end
    endtask

    task automatic test_sweep_wrap;
        in_valid = 1'b1; mode = 1'b1; in_sel = 3'd5; out_ready = 1'b1;
        tick;
        in_valid = 1'b0; mode = 1'b0;
        for (int k = 0; k < W; k++) begin
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_y !== act(line(5 + k)) || in_ready !== 1'b0 || sweep_done !== 1'b0)
                begin errors++; $display("FAIL sweep_beat[%0d] got v=%b y=%h rdy=%b done=%b want v=1 y=%h rdy=0 done=0",
                                         k, out_valid, out_y, in_ready, sweep_done, act(line(5 + k))); end
            tick;
        end
        checks++;
        if (sweep_done !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0 || out_y !== act('0))
            begin errors++; $display("FAIL sweep_done_cycle got done=%b v=%b rdy=%b y=%h want done=1 v=0 rdy=0 y=%h",
                                     sweep_done, out_valid, in_ready, out_y, act('0)); end
        tick;
        checks++;
        if (sweep_done !== 1'b0 || in_ready !== 1'b1)
            begin errors++; $display("FAIL sweep_after got done=%b rdy=%b want done=0 rdy=1", sweep_done, in_ready); end
    endtask

    // use_rst selects abort by reset instead of by en.
    task automatic test_abort(input bit use_rst);
        in_valid = 1'b1; mode = 1'b1; in_sel = 3'd1; out_ready = 1'b1;
        tick;
        in_valid = 1'b0; mode = 1'b0;
        tick; tick;
        checks++;
        if (out_y !== act(8'h08)) begin errors++; $display("FAIL abort_pre[%0d] got %h want %h", use_rst, out_y, act(8'h08)); end
        if (use_rst) rst = 1'b1; else en = 1'b0;
        tick;
        checks++;
        if (out_valid !== 1'b0 || out_y !== act('0) || sweep_done !== 1'b0)
            begin errors++; $display("FAIL abort_clear[%0d] got v=%b y=%h done=%b want v=0 y=%h done=0",
                                     use_rst, out_valid, out_y, sweep_done, act('0)); end
        rst = 1'b0; en = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_ready[%0d] got %b want 1", use_rst, in_ready); end
        tick;
        checks++;
        if (sweep_done !== 1'b0 || out_valid !== 1'b0)
            begin errors++; $display("FAIL abort_quiet[%0d] got done=%b v=%b want 0 0", use_rst, sweep_done, out_valid); end
        in_valid = 1'b1; in_sel = 3'd2;
        tick;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_y !== act(8'h04))
            begin errors++; $display("FAIL abort_direct[%0d] got v=%b y=%h want v=1 y=%h", use_rst, out_valid, out_y, act(8'h04)); end
        tick;
    endtask

    // Reference: the output is either idle, a single direct beat, or a sweep
    // with some number of beats still to deliver starting at the current line.
    task automatic test_random;
        bit m_valid, m_done, m_rdy, acc, cons;
        int m_idx, m_left;
        m_valid = 0; m_done = 0; m_idx = 0; m_left = 0;
        rst = 1'b1; en = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        tick;
        rst = 1'b0;
        for (int c = 0; c < 600; c++) begin
            rst       = ($urandom_range(0, 59) == 0);
            en        = ($urandom_range(0, 29) != 0);
            in_valid  = $urandom_range(0, 1) == 1;
            mode      = ($urandom_range(0, 3) == 0);
            in_sel    = N_IN'($urandom_range(0, W - 1));
            out_ready = ($urandom_range(0, 9) < 7);
            #1;
            m_rdy = !rst && en && (m_left == 0) && !m_done && (!m_valid || out_ready);
            checks++;
            if (out_valid !== m_valid || out_y !== act(m_valid ? line(m_idx) : '0)
                || in_ready !== m_rdy || sweep_done !== m_done)
                begin errors++; $display("FAIL random[%0d] got v=%b y=%h rdy=%b done=%b want v=%b y=%h rdy=%b done=%b",
                                         c, out_valid, out_y, in_ready, sweep_done,
                                         m_valid, act(m_valid ? line(m_idx) : '0), m_rdy, m_done); end
            acc  = in_valid && m_rdy;
            cons = m_valid && out_ready;
            if (rst || !en) begin
                m_valid = 0; m_left = 0; m_done = 0;
            end else begin
                m_done = 0;
                if (m_left > 0) begin
                    if (cons) begin
                        if (m_left == 1) begin m_valid = 0; m_left = 0; m_done = 1; end
                        else begin m_idx = (m_idx + 1) % W; m_left--; end
                    end
                end else if (acc) begin
                    m_valid = 1; m_idx = int'(in_sel); m_left = mode ? W : 0;
                end else if (cons) begin
                    m_valid = 0;
                end
            end
            tick;
        end
        rst = 1'b0; en = 1'b1; in_valid = 1'b0;
    endtask

    initial begin
        test_reset;
        test_direct_stream;
        test_backpressure;
        test_sweep_wrap;
        test_abort(1'b0);
        test_abort(1'b1);
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
